// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the
// presentation port into the instruction buffer.
interface fetch_ctrl_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] buf_pc;
  logic [31:0] buf_rdata;
  logic        buf_ready;
  logic        buf_clear;
  logic        buf_stall;

  modport master (
    output imem_valid, imem_addr,
    input  imem_ready, imem_rdata,
    output buf_pc, buf_rdata, buf_ready, buf_clear,
    input  buf_stall
  );

  modport slave (
    input  imem_valid, imem_addr,
    output imem_ready, imem_rdata,
    input  buf_pc, buf_rdata, buf_ready, buf_clear,
    output buf_stall
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch front end: single-outstanding imem handshake, forwards
// each word with its PC to the instruction buffer, replays rejects, flushes on redirect.
module fetch_ctrl #(
  parameter logic [31:0] reset_pc = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:1] fpc;        // bit 0 of the fetch PC is always zero, so it is not stored
  logic        kill;
  logic        clear_q;
  logic [31:0] hold_data;

  logic [31:1] fpc_adv;
  logic        unused_redirect_lsb;

  assign fpc_adv             = {fpc[31:2] + 30'd1, 1'b0};
  assign unused_redirect_lsb = redirect_pc[0];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      fpc       <= reset_pc[31:1];
      kill      <= 1'b0;
      clear_q   <= 1'b0;
      hold_data <= 32'h0;
    end else begin
      clear_q <= redirect;
      if (state == IDLE) begin
        // Reset acts as an implicit redirect to reset_pc.
        state   <= ISSUE;
        clear_q <= 1'b1;
      end else if (redirect) begin
        fpc <= redirect_pc[31:1];
        case (state)
          ISSUE: begin
            kill  <= 1'b1;
            state <= ISSUE;
          end
          WAIT: begin
            if (bus.imem_ready) begin
              kill  <= 1'b0;
              state <= ISSUE;
            end else begin
              // Stay put so the stale response is absorbed here.
              kill <= 1'b1;
            end
          end
          default: state <= ISSUE;
        endcase
      end else begin
        case (state)
          ISSUE: state <= WAIT;
          WAIT: begin
            if (bus.imem_ready) begin
              if (kill) begin
                kill  <= 1'b0;
                state <= ISSUE;
              end else if (!bus.buf_stall) begin
                fpc   <= fpc_adv;
                state <= ISSUE;
              end else begin
                hold_data <= bus.imem_rdata;
                state     <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!bus.buf_stall) begin
              fpc   <= fpc_adv;
              state <= ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Outputs are decoded from state so the response reaches the buffer in the
  // same cycle; buf_stall only feeds the registers above, never these outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    bus.imem_valid = 1'b0;
    bus.imem_addr  = 32'h0;
    bus.buf_ready  = 1'b0;
    bus.buf_rdata  = 32'h0;
    bus.buf_pc     = 32'h0;
    bus.buf_clear  = reset && clear_q;
    if (reset && !redirect) begin
      case (state)
        ISSUE: begin
          bus.imem_valid = 1'b1;
          bus.imem_addr  = {fpc[31:2], 2'b00};
        end
        WAIT: begin
          if (bus.imem_ready && !kill) begin
            bus.buf_ready = 1'b1;
            bus.buf_rdata = bus.imem_rdata;
            bus.buf_pc    = {fpc, 1'b0};
          end
        end
        HOLD: begin
          bus.buf_ready = 1'b1;
          bus.buf_rdata = hold_data;
          bus.buf_pc    = {fpc, 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, stall replay, redirects (outstanding,
// same-cycle, back-to-back) and reset from HOLD, against a latency-programmable memory.
module tb_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  int          checks;
  int          failures;

  // Memory model state: responds with the request address as data.
  int          mem_lat;
  bit          mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.reset_pc(32'h100)) dut (
    .clock      (clock),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .bus        (bus.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Request is captured mid-cycle; response appears mem_lat cycles later.
  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    mem_pending    = 1'b0;
    mem_cnt        = 0;
    mem_addr       = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        mem_pending = 1'b0;
      end else if (bus.imem_valid) begin
        mem_pending = 1'b1;
        mem_cnt     = mem_lat;
        mem_addr    = bus.imem_addr;
      end
      @(posedge clock);
      #1;
      bus.imem_ready = 1'b0;
      bus.imem_rdata = 32'h0;
      if (mem_pending) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          bus.imem_ready = 1'b1;
          bus.imem_rdata = mem_addr;
          mem_pending    = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample all outputs mid-cycle, then advance to the next drive point.
  task automatic step(input string tag, input logic ev, input logic [31:0] ea,
                      input logic er, input logic [31:0] ep, input logic [31:0] ed,
                      input logic ec);
    @(negedge clock);
    check({tag, ".imem_valid"}, {31'h0, bus.imem_valid}, {31'h0, ev});
    check({tag, ".imem_addr"},  bus.imem_addr, ea);
    check({tag, ".buf_ready"},  {31'h0, bus.buf_ready}, {31'h0, er});
    check({tag, ".buf_pc"},     bus.buf_pc, ep);
    check({tag, ".buf_rdata"},  bus.buf_rdata, ed);
    check({tag, ".buf_clear"},  {31'h0, bus.buf_clear}, {31'h0, ec});
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    bus.buf_stall = 1'b0;
    mem_lat       = 1;
    @(posedge clock);
    #1;

    // Held in reset: everything quiet.
    step("rst_a", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step("rst_b", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    reset = 1'b1;

    // Boot: IDLE, then request 0x100 with the flush pulse.
    step("c0_idle", 0, 32'h0,   0, 32'h0,   32'h0,   0);
    step("c1",      1, 32'h100, 0, 32'h0,   32'h0,   1);
    step("c2",      0, 32'h0,   1, 32'h100, 32'h100, 0);
    step("c3",      1, 32'h104, 0, 32'h0,   32'h0,   0);

    // Word 0x104 rejected for 3 cycles, then accepted.
    bus.buf_stall = 1'b1;
    step("c4_stall", 0, 32'h0, 1, 32'h104, 32'h104, 0);
    step("c5_hold",  0, 32'h0, 1, 32'h104, 32'h104, 0);
    step("c6_hold",  0, 32'h0, 1, 32'h104, 32'h104, 0);
    bus.buf_stall = 1'b0;
    step("c7_accept", 0, 32'h0,   1, 32'h104, 32'h104, 0);
    step("c8",        1, 32'h108, 0, 32'h0,   32'h0,   0);
    step("c9",        0, 32'h0,   1, 32'h108, 32'h108, 0);

    // Slow request to 0x10C, redirected to 0x2002 while outstanding.
    mem_lat = 4;
    step("c10", 1, 32'h10C, 0, 32'h0, 32'h0, 0);
    mem_lat     = 1;
    redirect    = 1'b1;
    redirect_pc = 32'h2002;
    step("c11_redir", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    redirect = 1'b0;
    step("c12_clear", 0, 32'h0,    0, 32'h0,    32'h0,    1);
    step("c13_wait",  0, 32'h0,    0, 32'h0,    32'h0,    0);
    step("c14_stale", 0, 32'h0,    0, 32'h0,    32'h0,    0);
    step("c15",       1, 32'h2000, 0, 32'h0,    32'h0,    0);
    step("c16",       0, 32'h0,    1, 32'h2002, 32'h2000, 0);
    step("c17",       1, 32'h2004, 0, 32'h0,    32'h0,    0);
    step("c18",       0, 32'h0,    1, 32'h2004, 32'h2004, 0);
    step("c19",       1, 32'h2008, 0, 32'h0,    32'h0,    0);

    // Redirect coincides with the response.
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    step("c20_redir_rdy", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    redirect = 1'b0;
    step("c21", 1, 32'h500, 0, 32'h0,   32'h0,   1);
    step("c22", 0, 32'h0,   1, 32'h500, 32'h500, 0);

    // Back-to-back redirects while a request is outstanding.
    mem_lat = 3;
    step("c23", 1, 32'h504, 0, 32'h0, 32'h0, 0);
    mem_lat     = 1;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    step("c24_redir300", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    redirect_pc = 32'h400;
    step("c25_redir400", 0, 32'h0, 0, 32'h0, 32'h0, 1);
    redirect = 1'b0;
    step("c26_stale", 0, 32'h0,   0, 32'h0,   32'h0,   1);
    step("c27",       1, 32'h400, 0, 32'h0,   32'h0,   0);
    step("c28",       0, 32'h0,   1, 32'h400, 32'h400, 0);
    step("c29",       1, 32'h404, 0, 32'h0,   32'h0,   0);

    // Reset while holding a rejected word, then the boot sequence again.
    bus.buf_stall = 1'b1;
    step("c30_stall", 0, 32'h0, 1, 32'h404, 32'h404, 0);
    step("c31_hold",  0, 32'h0, 1, 32'h404, 32'h404, 0);
    reset = 1'b0;
    step("c32_rst", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step("c33_rst", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    reset         = 1'b1;
    bus.buf_stall = 1'b0;
    step("c34_idle", 0, 32'h0,   0, 32'h0,   32'h0,   0);
    step("c35",      1, 32'h100, 0, 32'h0,   32'h0,   1);
    step("c36",      0, 32'h0,   1, 32'h100, 32'h100, 0);
    step("c37",      1, 32'h104, 0, 32'h0,   32'h0,   0);
    step("c38",      0, 32'h0,   1, 32'h104, 32'h104, 0);
    step("c39",      1, 32'h108, 0, 32'h0,   32'h0,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
